// File: rtl/fixed_argmax_pkg.sv
// Shared helpers for the fixed_argmax classifier head.
package fixed_argmax_pkg;

    // Ceiling log2, returning 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

    // Ceiling log2 clamped to at least one bit, for index and counter widths.
    function automatic int clog2_min1(input int value);
        int res;
        res = clog2(value);
        if (res < 1) begin
            res = 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fixed_argmax_tree.sv
// Combinational N-input signed max/index tree. On equal values the lower
// index wins, so the result is the first occurrence of the maximum.
module fixed_argmax_tree
    import fixed_argmax_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N      = 10,
    parameter int IDX_W  = clog2_min1(N)
) (
    input  logic [DATA_W-1:0] data [N],
    output logic [DATA_W-1:0] max_val,
    output logic [IDX_W-1:0]  max_idx
);

    // Pairwise reduction by doubling stride; the left (lower-index) side is kept unless the right is strictly larger
    always_comb begin : reduce
        logic [DATA_W-1:0] val [N];
        logic [IDX_W-1:0]  idx [N];
        for (int i = 0; i < N; i++) begin
            val[i] = data[i];
            idx[i] = IDX_W'(i);
        end
        for (int s = 1; s < N; s = s * 2) begin
            for (int i = 0; i + s < N; i = i + 2 * s) begin
                if ($signed(val[i + s]) > $signed(val[i])) begin
                    val[i] = val[i + s];
                    idx[i] = idx[i + s];
                end else begin
                    val[i] = val[i];
                    idx[i] = idx[i];
                end
            end
        end
        max_val = val[0];
        max_idx = idx[0];
    end

endmodule

// File: rtl/fixed_argmax.sv
// Streaming argmax head: accumulates a running signed maximum per row across
// BEATS input beats and emits the index of the first largest element.
module fixed_argmax
    import fixed_argmax_pkg::*;
#(
    parameter int DATA_IN_0_PRECISION_0       = 32,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 10,
    parameter int DATA_IN_0_PARALLELISM_DIM_0 = 10,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
    parameter int DATA_OUT_0_PRECISION_0      = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
    input  logic                              data_in_0_valid,
    output logic                              data_in_0_ready,
    output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0 [DATA_IN_0_PARALLELISM_DIM_1],
    output logic                              data_out_0_valid,
    input  logic                              data_out_0_ready
);

    localparam int DIN_W  = DATA_IN_0_PRECISION_0;
    localparam int P0     = DATA_IN_0_PARALLELISM_DIM_0;
    localparam int P1     = DATA_IN_0_PARALLELISM_DIM_1;
    localparam int T0     = DATA_IN_0_TENSOR_SIZE_DIM_0;
    localparam int OUT_W  = DATA_OUT_0_PRECISION_0;
    localparam int BEATS  = T0 / P0;
    localparam int BEAT_W = clog2_min1(BEATS);
    localparam int COL_W  = clog2_min1(P0);
    localparam int IDX_W  = clog2_min1(T0);

    logic [BEAT_W-1:0] beat_r;
    logic [DIN_W-1:0]  run_max_r  [P1];
    logic [IDX_W-1:0]  run_idx_r  [P1];
    logic [DIN_W-1:0]  loc_max_s  [P1];
    logic [COL_W-1:0]  loc_col_s  [P1];
    logic [IDX_W-1:0]  loc_idx_s  [P1];
    logic [DIN_W-1:0]  next_max_s [P1];
    logic [IDX_W-1:0]  next_idx_s [P1];
    logic [OUT_W-1:0]  dout_r     [P1];
    logic              valid_r;
    logic              accept_s;
    logic              last_beat_s;

    assign data_in_0_ready  = !valid_r || data_out_0_ready;
    assign accept_s         = data_in_0_valid && data_in_0_ready;
    assign last_beat_s      = (beat_r == BEAT_W'(BEATS - 1));
    assign data_out_0       = dout_r;
    assign data_out_0_valid = valid_r;

    for (genvar r = 0; r < P1; r++) begin : g_row
        logic [DIN_W-1:0] row_s [P0];

        // Select the P0 columns belonging to row r of the beat
        always_comb begin
            for (int c = 0; c < P0; c++) begin
                row_s[c] = data_in_0[r * P0 + c];
            end
        end

        fixed_argmax_tree #(
            .DATA_W (DIN_W),
            .N      (P0),
            .IDX_W  (COL_W)
        ) u_tree (
            .data    (row_s),
            .max_val (loc_max_s[r]),
            .max_idx (loc_col_s[r])
        );
    end

    // Merge the beat-local winner into the running winner; beat 0 loads, later beats need a strict win
    always_comb begin
        for (int r = 0; r < P1; r++) begin
            loc_idx_s[r] = IDX_W'(beat_r) * IDX_W'(P0) + IDX_W'(loc_col_s[r]);
            if (beat_r == BEAT_W'(0)) begin
                next_max_s[r] = loc_max_s[r];
                next_idx_s[r] = loc_idx_s[r];
            end else if ($signed(loc_max_s[r]) > $signed(run_max_r[r])) begin
                next_max_s[r] = loc_max_s[r];
                next_idx_s[r] = loc_idx_s[r];
            end else begin
                next_max_s[r] = run_max_r[r];
                next_idx_s[r] = run_idx_r[r];
            end
        end
    end

    // Beat counter: advances on each accepted beat and wraps after the last beat of a row
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_r <= {BEAT_W{1'b0}};
        end else if (accept_s) begin
            if (last_beat_s) begin
                beat_r <= {BEAT_W{1'b0}};
            end else begin
                beat_r <= beat_r + BEAT_W'(1);
            end
        end
    end

    // Running maximum and index per row, updated only on accepted beats
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < P1; r++) begin
                run_max_r[r] <= {DIN_W{1'b0}};
                run_idx_r[r] <= {IDX_W{1'b0}};
            end
        end else if (accept_s) begin
            for (int r = 0; r < P1; r++) begin
                run_max_r[r] <= next_max_s[r];
                run_idx_r[r] <= next_idx_s[r];
            end
        end
    end

    // Output register: loads on the last beat, otherwise holds until the consumer takes it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= 1'b0;
            for (int r = 0; r < P1; r++) begin
                dout_r[r] <= {OUT_W{1'b0}};
            end
        end else if (accept_s && last_beat_s) begin
            valid_r <= 1'b1;
            for (int r = 0; r < P1; r++) begin
                dout_r[r] <= OUT_W'(next_idx_s[r]);
            end
        end else if (data_out_0_ready) begin
            valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fixed_argmax.sv
// Directed bench for fixed_argmax: one instance with a single 10-wide beat
// per row and one with two 5-wide beats per row, checked against a full-row
// reference argmax through per-instance result queues.
module tb_fixed_argmax;

    logic        clk;
    logic        rst;

    logic [31:0] a_din [10];
    logic        a_vin;
    logic        a_rdy;
    logic [3:0]  a_dout [1];
    logic        a_vout;
    logic        a_rout;

    logic [31:0] b_din [5];
    logic        b_vin;
    logic        b_rdy;
    logic [3:0]  b_dout [1];
    logic        b_vout;
    logic        b_rout;

    int          errors;
    int          checks;
    int          qa[$];
    int          qb[$];
    int          pops_a;
    int          pops_b;
    bit          a_acc;
    bit          b_acc;

    fixed_argmax dut_a (
        .clk              (clk),
        .rst              (rst),
        .data_in_0        (a_din),
        .data_in_0_valid  (a_vin),
        .data_in_0_ready  (a_rdy),
        .data_out_0       (a_dout),
        .data_out_0_valid (a_vout),
        .data_out_0_ready (a_rout)
    );

    fixed_argmax #(
        .DATA_IN_0_PARALLELISM_DIM_0 (5)
    ) dut_b (
        .clk              (clk),
        .rst              (rst),
        .data_in_0        (b_din),
        .data_in_0_valid  (b_vin),
        .data_in_0_ready  (b_rdy),
        .data_out_0       (b_dout),
        .data_out_0_valid (b_vout),
        .data_out_0_ready (b_rout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic int ref_argmax(input int r[10]);
        int best;
        best = 0;
        for (int i = 1; i < 10; i++) begin
            if (r[i] > r[best]) best = i;
        end
        return best;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes on the falling edge, score outputs, then move past the rising edge.
    task automatic step();
        int e;
        @(negedge clk);
        a_acc = a_vin && a_rdy;
        b_acc = b_vin && b_rdy;
        if (a_vout && a_rout) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_result", qa.size(), 1);
            end else begin
                e = qa.pop_front();
                chk("a_result", a_dout[0], e);
                pops_a++;
            end
        end
        if (b_vout && b_rout) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_result", qb.size(), 1);
            end else begin
                e = qb.pop_front();
                chk("b_result", b_dout[0], e);
                pops_b++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input int r[10], output int cyc);
        for (int i = 0; i < 10; i++) a_din[i] = r[i];
        a_vin = 1'b1;
        qa.push_back(ref_argmax(r));
        cyc = 0;
        a_acc = 1'b0;
        while (!a_acc && cyc < 40) begin
            step();
            cyc++;
        end
        chk("a_accept", a_acc, 1);
        a_vin = 1'b0;
    endtask

    task automatic send_b_beat(input int r[10], input int base);
        int n;
        for (int i = 0; i < 5; i++) b_din[i] = r[base + i];
        b_vin = 1'b1;
        n = 0;
        b_acc = 1'b0;
        while (!b_acc && n < 40) begin
            step();
            n++;
        end
        chk("b_accept", b_acc, 1);
        b_vin = 1'b0;
    endtask

    task automatic send_b(input int r[10]);
        send_b_beat(r, 0);
        qb.push_back(ref_argmax(r));
        send_b_beat(r, 5);
    endtask

    task automatic drain();
        a_vin = 1'b0;
        b_vin = 1'b0;
        for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) step();
        chk("a_drained", qa.size(), 0);
        chk("b_drained", qb.size(), 0);
    endtask

    initial begin
        int cyc;
        int row[10];
        int base;
        errors = 0;
        checks = 0;
        pops_a = 0;
        pops_b = 0;
        rst    = 1'b0;
        a_vin  = 1'b0;
        b_vin  = 1'b0;
        a_rout = 1'b1;
        b_rout = 1'b1;
        for (int i = 0; i < 10; i++) a_din[i] = 32'd0;
        for (int i = 0; i < 5; i++) b_din[i] = 32'd0;

        // Reset state
        #2;
        chk("rst_a_valid", a_vout, 0);
        chk("rst_a_data", a_dout[0], 0);
        chk("rst_b_valid", b_vout, 0);
        chk("rst_b_data", b_dout[0], 0);
        chk("rst_a_ready", a_rdy, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();

        // Single-beat row; result valid for exactly one cycle
        send_a('{3, 9, 1, 9, 0, 0, 0, 0, 0, 2}, cyc);
        chk("t1_valid", a_vout, 1);
        chk("t1_data", a_dout[0], 1);
        step();
        chk("t1_valid_clears", a_vout, 0);

        // Two-beat rows, including a cross-beat tie
        send_b('{1, 2, 3, 4, 5, 5, 0, 7, 7, 1});
        send_b('{8, 0, 0, 0, 0, 8, 8, 0, 0, 0});
        send_b('{-9, -9, -9, -9, -9, -3, -9, -3, -9, -9});
        drain();

        // Signed values and the most negative value
        send_a('{-5, -2, -9, -2, -100, -7, -3, -8, -6, -4}, cyc);
        send_a('{int'(32'h8000_0000), int'(32'h8000_0000), int'(32'h8000_0000),
                 int'(32'h8000_0000), int'(32'h8000_0000), int'(32'h8000_0000),
                 int'(32'h8000_0000), int'(32'h8000_0000), int'(32'h8000_0000),
                 int'(32'h8000_0000)}, cyc);
        send_a('{int'(32'h8000_0000), -1, int'(32'h7FFF_FFFF), 0, 5, 5, 5, 5, 5, int'(32'h7FFF_FFFF)}, cyc);
        drain();

        // Backpressure: result held, input stalled, then released in order
        a_rout = 1'b0;
        send_a('{0, 1, 50, 3, 4, 5, 6, 7, 8, 9}, cyc);
        for (int i = 0; i < 10; i++) a_din[i] = (i == 7) ? 32'd70 : 32'd1;
        a_vin = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("bp_in_ready_low", a_rdy, 0);
            chk("bp_valid_held", a_vout, 1);
            chk("bp_data_held", a_dout[0], 2);
        end
        a_rout = 1'b1;
        base = pops_a;
        send_a('{1, 1, 1, 1, 1, 1, 1, 70, 1, 1}, cyc);
        send_a('{-1, -1, -1, -1, -1, -1, -1, -1, -1, 0}, cyc);
        drain();
        chk("bp_result_count", pops_a - base, 3);

        // Throughput: one row per cycle with ready held high
        base = pops_a;
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 10; i++) row[i] = int'($urandom_range(0, 30)) - 15;
            send_a(row, cyc);
            chk("tp_one_cycle", cyc, 1);
        end
        a_vin = 1'b0;
        step();
        chk("tp_result_count", pops_a - base, 20);
        drain();

        // Reset mid-row discards the partial row
        send_b_beat('{9, 9, 9, 9, 9, 9, 9, 9, 9, 9}, 0);
        rst = 1'b0;
        #1;
        chk("midrst_b_valid", b_vout, 0);
        chk("midrst_b_data", b_dout[0], 0);
        chk("midrst_a_valid", a_vout, 0);
        chk("midrst_a_data", a_dout[0], 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        chk("postrst_b_valid", b_vout, 0);
        send_b('{0, 0, 0, 0, 0, 0, 0, 0, 6, 0});
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
